// File: rtl/divider_nr_signed.sv
// Signed non-restoring iterative divider with busy/abort handshake and restart.
// Define DIV_REMAINDER_EN to add the data_remainder port and the remainder restore step.
module divider_nr_signed #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   p_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] b_q;
  logic             signQ_q;
  logic             zeroB_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy_q;
  logic             busy_q;

  logic [WIDTH-1:0] absA_d;
  logic [WIDTH-1:0] absB_d;
  logic [WIDTH:0]   bExt;
  logic [WIDTH:0]   pShift;
  logic [WIDTH:0]   p_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] quot_d;

  // Magnitudes are unsigned, so the most negative operand maps onto 2^(WIDTH-1) without overflow.
  assign absA_d = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign absB_d = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign bExt   = {1'b0, b_q};

  // The shifted remainder may wrap out of WIDTH+1 bits, but the add/subtract always lands back in range.
  assign pShift = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign p_d    = p_q[WIDTH] ? (pShift + bExt) : (pShift - bExt);
  assign q_d    = {q_q[WIDTH-2:0], ~p_d[WIDTH]};
  assign quot_d = zeroB_q ? '0 : (signQ_q ? -q_q : q_q);

`ifdef DIV_REMAINDER_EN
  logic             signA_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH:0]   pFix_d;
  logic [WIDTH-1:0] rem_d;

  assign pFix_d = p_q[WIDTH] ? (p_q + bExt) : p_q;
  assign rem_d  = signA_q ? -pFix_d[WIDTH-1:0] : pFix_d[WIDTH-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      signA_q <= 1'b0;
      rem_q   <= '0;
    end else if (!ctrl_MULT && ctrl_DIV) begin
      signA_q <= data_operandA[WIDTH-1];
    end else if (!ctrl_MULT && state_q == FIX) begin
      rem_q   <= rem_d;
    end
  end

  assign data_remainder = rem_q;
`endif

  // Abort beats start, and start beats whatever job is in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      q_q      <= '0;
      b_q      <= '0;
      signQ_q  <= 1'b0;
      zeroB_q  <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (ctrl_MULT) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (ctrl_DIV) begin
      state_q <= RUN;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= absA_d;
      b_q     <= absB_d;
      signQ_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      zeroB_q <= (data_operandB == '0);
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= quot_d;
          exc_q    <= zeroB_q;
          rdy_q    <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= DONE;
        end
        DONE: begin
          rdy_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: doc/divider_nr_signed.md
Name: divider_nr_signed

Overview:
- Parametrised signed non-restoring iterative divider; successor to the 32-bit multdiv divider.
- Generalised to WIDTH bits, with correct signed semantics for all operands, including negative partial remainders.
- Adds a final remainder-correction step, busy/abort handshake, restart and async reset.
- Sits inside multdiv beside the multiplier and shares its ctrl_MULT/ctrl_DIV strobes; the pipeline stalls on data_resultRDY.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits (>=4).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous active-high reset
data_operandA  input  WIDTH  dividend, two's complement, sampled on start edge only
data_operandB  input  WIDTH  divisor, two's complement, sampled on start edge only
ctrl_DIV  input  1  start strobe, one-cycle pulse
ctrl_MULT  input  1  abort strobe (multiplier starting); cancels any division in flight
data_result  output  WIDTH  quotient, registered, held until next completion
data_remainder  output  WIDTH  remainder, registered (present only with DIV_REMAINDER_EN)
data_exception  output  1  divide-by-zero flag, valid with data_resultRDY, held with result
data_resultRDY  output  1  one-cycle completion pulse
busy  output  1  high while a division is in flight (RUN or FIX)

Behaviour:
- Reset (async, any state): state=IDLE, counter=0. data_result, data_remainder, data_exception, data_resultRDY and busy all 0.
- States: IDLE, RUN, FIX, DONE.
- Start: ctrl_DIV=1 and ctrl_MULT=0 at an edge, in any state, does the following:
  - latches |A| and |B| as WIDTH-bit unsigned magnitudes (|-2^(W-1)| = 2^(W-1) fits unsigned);
  - latches signA, signQ=signA^signB and zeroB=(B==0);
  - clears partial remainder P (WIDTH+1 bits, signed); loads Q=|A|; counter=0; goes to RUN.
  - Restart from RUN/FIX discards the old job; data_resultRDY is not pulsed for the discarded job.
- Abort: ctrl_MULT=1 at an edge goes to IDLE and clears busy. Outputs keep their previous values. ctrl_MULT wins over a simultaneous ctrl_DIV.
- RUN (one iteration per edge, exactly WIDTH edges):
  - shift {P,Q} left 1;
  - if old P negative, P += |B|, else P -= |B|;
  - Q[0] = ~P_new[sign].
  - At counter==WIDTH-1, go to FIX.
- FIX (one edge):
  - if P negative, P += |B|;
  - quotient = signQ ? -Q : Q; remainder = signA ? -P : P (low WIDTH bits).
  - Register into outputs; data_exception=zeroB; data_resultRDY=1; go to DONE.
- DONE: data_resultRDY high for exactly this cycle; next edge goes to IDLE with RDY=0. Outputs held.
- Latency: with the start edge at E0, iterations run on E1..EW, FIX is E(W+1), and RDY is high between E(W+1) and E(W+2). That is W+1 cycles from start, independent of operands.
- busy=1 from the edge after start through the FIX edge inclusive; 0 in IDLE/DONE.
- Semantics: truncation toward zero; remainder takes the dividend's sign; A = Q*B + R.
- Divide by zero: runs full latency; data_result=0, data_remainder=A, data_exception=1.
- Overflow (-2^(W-1) / -1): quotient wraps to -2^(W-1), remainder 0, data_exception=0.
- Operand inputs are ignored except on the start edge; they may change freely while busy.

Optional Feature:
DIV_REMAINDER_EN: when defined, the data_remainder port and its register exist with the behaviour above. When undefined, the port is absent, the FIX step applies only the quotient sign (the remainder restore add is removed), and latency is unchanged at W+1.

Test Plan:
- WIDTH=32, A=100, B=7 -> after 33 cycles RDY pulse 1 cycle, result=14, remainder=2, exception=0.
- Signed matrix: -100/7 -> -14 r -2; 100/-7 -> -14 r 2; -100/-7 -> 14 r -2; 0/5 -> 0 r 0.
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, remainder=0, exception=0; A=123, B=0 -> result=0, remainder=123, exception=1.
- Start 100/7, then at cycle 10 start 50/5 -> single RDY at 33 cycles after the second start, result=10; ctrl_MULT at cycle 5 of a job -> busy drops next edge, no RDY, prior outputs unchanged.
- Reset asserted asynchronously mid-RUN -> all outputs 0 immediately; a new start after release completes normally.
- WIDTH=8 instance, randomised 10k operand pairs vs reference model (truncating division) -> all match, latency 9 cycles; repeat with DIV_REMAINDER_EN undefined, quotient only.
